// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select codes and control FSM state encoding for hazard_ctrl.
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic [1:0] {IDLE, DIV_BUSY, EXC_FLUSH} ctrlState;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: E-stage operand forward select, M result wins over W, r0 never forwarded.
module hazard_fwd_sel import hazard_pkg::*; #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic [1:0]        fwd
);
    always_comb
        fwd = (src != '0 && src == writeregM && regwriteM) ? FWD_MEM :
              (src != '0 && src == writeregW && regwriteW) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding/stall/flush control with divider stall and exception flush FSM.
// Optional stall-cycle counter port stall_cycles enabled by HAZARD_PERF_EN.
module hazard_ctrl import hazard_pkg::*; #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divstartE,
    input  logic              div_ready,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic              exceptM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              div_cancel,
    output logic              excredirect
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles
`endif
);
    ctrlState state;
    logic [3:0] cnt;
    logic [1:0] fwdA, fwdB;
    logic lwStall, ctlStall, inFlush, excTake, divWait, simpleStall;

    hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (.src(rsE), .writeregM(writeregM), .regwriteM(regwriteM),
        .writeregW(writeregW), .regwriteW(regwriteW), .fwd(fwdA));
    hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (.src(rtE), .writeregM(writeregM), .regwriteM(regwriteM),
        .writeregW(writeregW), .regwriteW(regwriteW), .fwd(fwdB));

    // A D-stage compare needs the register from E (any write) or from an M-stage load.
    function automatic logic dep(input logic [REG_AW-1:0] r);
        return (regwriteE && writeregE != '0 && writeregE == r) ||
               (memtoregM && writeregM != '0 && writeregM == r);
    endfunction

    always_comb begin
        lwStall     = memtoregE && writeregE != '0 && (writeregE == rsD || writeregE == rtD);
        ctlStall    = (branchD || jrD) && (dep(rsD) || (branchD && dep(rtD)));
        inFlush     = state == EXC_FLUSH;
        excTake     = exceptM && !inFlush;
        divWait     = !excTake && !inFlush && !div_ready && (state == DIV_BUSY || divstartE);
        simpleStall = state == IDLE && !exceptM && !divWait && (lwStall || ctlStall);
        forwardaD   = !rst && rsD != '0 && rsD == writeregM && regwriteM;
        forwardbD   = !rst && rtD != '0 && rtD == writeregM && regwriteM;
        forwardaE   = rst ? FWD_RF : fwdA;
        forwardbE   = rst ? FWD_RF : fwdB;
        stallF      = !rst && (divWait || simpleStall);
        stallD      = stallF;
        stallE      = !rst && divWait;
        flushD      = !rst && (excTake || inFlush);
        flushE      = flushD || (!rst && simpleStall);
        flushM      = flushD || stallE;
        div_cancel  = !rst && excTake && state == DIV_BUSY;
        excredirect = !rst && excTake;
    end

    // The exception cycle itself is the first flush cycle; cnt counts the ones still to come.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (inFlush) begin
            cnt   <= cnt - 4'd1;
            state <= (cnt == 4'd1) ? IDLE : EXC_FLUSH;
        end else if (excTake) begin
            cnt   <= 4'(FLUSH_CYCLES - 1);
            state <= (FLUSH_CYCLES > 1) ? EXC_FLUSH : IDLE;
        end else begin
            state <= divWait ? DIV_BUSY : IDLE;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk)
        stall_cycles <= rst ? '0 : stall_cycles + PERF_W'(stallF);
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan cases plus randomized cycles against a behavioural model.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int FC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, jrD, regwriteE, memtoregE, divstartE, div_ready;
    logic regwriteM, memtoregM, exceptM, regwriteW;
    logic forwardaD, forwardbD, stallF, stallD, stallE, flushD, flushE, flushM, div_cancel, excredirect;
    logic [1:0] forwardaE, forwardbE;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .divstartE(divstartE), .div_ready(div_ready), .writeregM(writeregM), .regwriteM(regwriteM),
        .memtoregM(memtoregM), .exceptM(exceptM), .writeregW(writeregW), .regwriteW(regwriteW),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .div_cancel(div_cancel), .excredirect(excredirect)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int checks = 0;
    int failures = 0;
    bit busy = 1'b0;
    int flushLeft = 0;
    logic [31:0] perf = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [AW-1:0] s);
        if (s == 0) return 2'b00;
        if (s == writeregM && regwriteM) return 2'b10;
        if (s == writeregW && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit dep(input logic [AW-1:0] r);
        return (regwriteE && writeregE != 0 && writeregE == r) || (memtoregM && writeregM != 0 && writeregM == r);
    endfunction

    task automatic clr();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, jrD, regwriteE, memtoregE, divstartE, div_ready, regwriteM, memtoregM, exceptM, regwriteW} = '0;
    endtask

    // Check all outputs for the current inputs, advance the model, then cross one clock edge.
    task automatic step();
        bit sF, sE, fD, fE, fM, dc, er, lw, ctl, fa, fb;
        logic [13:0] exp;
        #1;
        {sF, sE, fD, fE, fM, dc, er} = '0;
        lw  = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
        ctl = (branchD || jrD) && (dep(rsD) || (branchD && dep(rtD)));
        if (flushLeft > 0) {fD, fE, fM} = 3'b111;
        else if (exceptM) {fD, fE, fM, er, dc} = {4'b1111, busy};
        else if (busy ? !div_ready : (divstartE && !div_ready)) {sF, sE, fM} = 3'b111;
        else if (!busy && (lw || ctl)) {sF, fE} = 2'b11;
        fa  = rsD != 0 && rsD == writeregM && regwriteM;
        fb  = rtD != 0 && rtD == writeregM && regwriteM;
        exp = rst ? 14'd0 : {fa, fb, fwd(rsE), fwd(rtE), sF, sF, sE, fD, fE, fM, dc, er};
        check("outs", 32'({forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE,
                           flushD, flushE, flushM, div_cancel, excredirect}), 32'(exp));
`ifdef HAZARD_PERF_EN
        check("perf", stall_cycles, perf);
`endif
        if (rst) begin
            busy = 1'b0;
            flushLeft = 0;
            perf = '0;
        end else begin
            if (exp[7]) perf = perf + 1;
            if (flushLeft > 0) flushLeft--;
            else if (exceptM) begin
                busy = 1'b0;
                flushLeft = FC - 1;
            end else busy = busy ? !div_ready : (divstartE && !div_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        #1 check("fwdMem", 32'(forwardaE), 32'd2);
        step();
        regwriteM = 0;
        #1 check("fwdWb", 32'(forwardaE), 32'd1);
        step();
        rsE = 0;
        #1 check("fwdR0", 32'(forwardaE), 32'd0);
        step();

        clr(); memtoregE = 1; writeregE = 8; rtD = 8;
        #1 check("lwStall", 32'({stallF, stallD, flushE}), 32'd7);
        step();
        clr(); memtoregM = 1; writeregM = 8; rtD = 8;
        #1 check("lwOnce", 32'(stallF), 32'd0);
        step();
        clr(); memtoregE = 1;
        #1 check("lwR0", 32'(stallF), 32'd0);
        step();

        clr(); jrD = 1; rsD = 31; regwriteE = 1; writeregE = 31;
        #1 check("jrStall", 32'(stallF), 32'd1);
        step();
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 31;
        #1 check("jrFwd", 32'({stallF, forwardaD}), 32'd1);
        step();

        clr(); divstartE = 1;
        for (int i = 0; i < 5; i++) begin
            #1 check("divStall", 32'({stallF, stallD, stallE, flushM}), 32'hF);
            step();
        end
        div_ready = 1;
        #1 check("divDone", 32'({stallF, stallD, stallE, flushM}), 32'd0);
        step();
        clr();
        step();

        divstartE = 1;
        step();
        step();
        divstartE = 0; exceptM = 1;
        #1 check("excCancel", 32'({div_cancel, excredirect, flushD, flushE, flushM, stallF}), 32'b111110);
        step();
        exceptM = 0;
        #1 check("excFlush2", 32'({div_cancel, excredirect, flushD, flushE, flushM}), 32'b00111);
        step();
        #1 check("excFlush3", 32'({flushD, flushE, flushM}), 32'b111);
        step();
        #1 check("excDone", 32'({flushD, flushE, flushM}), 32'd0);
        step();

        divstartE = 1;
        step();
        step();
        rst = 1;
        #1 check("rstOuts", 32'({stallF, stallE, flushM}), 32'd0);
        step();
        rst = 0; divstartE = 0;
        #1 check("rstIdle", 32'({stallF, stallE, flushM}), 32'd0);
`ifdef HAZARD_PERF_EN
        check("perfRst", stall_cycles, 32'd0);
`endif
        step();

        for (int n = 0; n < 600; n++) begin
            rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
            rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
            writeregE = AW'($urandom_range(0, 3)); writeregM = AW'($urandom_range(0, 3));
            writeregW = AW'($urandom_range(0, 3));
            {branchD, jrD, regwriteE, memtoregE, regwriteM, memtoregM, regwriteW} = 7'($urandom);
            divstartE = $urandom_range(0, 5) == 0;
            div_ready = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            exceptM   = $urandom_range(0, 19) == 0;
            rst       = $urandom_range(0, 59) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
